// File: rtl/alu_muldiv_pkg.sv
// Package alu_pkg: op codes and the multiply/divide sequencer state encoding
// shared by alu_muldiv and muldiv_iter.
//
// Op code layout:
//   op[3]=0  legacy group. op[2] inverts b. op[1:0] picks the function:
//            AND / OR / ADD / set-less-than.
//   op[3]=1  extended group: XOR, NOR, shifts, MUL, DIV, MFHI.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_ANDN = 4'b0100;
    localparam logic [3:0] OP_ORN  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_DIV  = 4'b1110;
    localparam logic [3:0] OP_MFHI = 4'b1111;

    // Multiply/divide sequencer: IDLE -> ITER (WIDTH steps) -> FIX -> IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply / restoring divide with HI register.
//
// A start_i pulse (only honoured in S_IDLE) latches magnitudes of the operands
// and the signs the result needs. ITER then runs one radix-2 step per cycle for
// WIDTH cycles; FIX applies the signs, writes HI and presents the LO value on
// lo_fix_o while done_o is high (one cycle). HI changes only in FIX.
//
// Ports:
//   clk, rst_n     clock, async active-low reset (aborts any operation)
//   start_i        begin an operation this edge (caller guarantees S_IDLE)
//   is_div_i       1 = divide, 0 = multiply
//   signed_i       operands are two's complement
//   a_i, b_i       operands (dividend/divisor for DIV)
//   done_o         high during FIX: lo_fix_o is the final LO this cycle
//   lo_fix_o       product low half / quotient, valid with done_o
//   hi_o           HI register (product high half / remainder)
//   state_o        sequencer state, also used by the top for issue control
module muldiv_iter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_fix_o,
    output logic [WIDTH-1:0] hi_o,
    output md_state_e        state_o
);

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // acc: product high half (MUL) / partial remainder (DIV)
    // work: multiplier shifting out, product low half shifting in (MUL) /
    //       dividend shifting out, quotient shifting in (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;  // negate product / quotient
    logic             neg_rem_q, neg_rem_d;  // negate remainder (sign of a)
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_abs, prod_fix;

    assign abs_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign abs_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the whole {acc, work} pair right by one.
    assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring divide step. The partial remainder is always below the
    // divisor, so when div_ge holds the difference fits in WIDTH bits.
    assign div_shift = {acc_q, work_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    assign prod_abs  = {acc_q, work_q};
    assign prod_fix  = neg_res_q ? -prod_abs : prod_abs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        done_o    = 1'b0;
        lo_fix_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_ITER;
                    cnt_d     = '0;
                    acc_d     = '0;
                    work_d    = abs_a;
                    opnd_d    = abs_b;
                    is_div_d  = is_div_i;
                    neg_res_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_rem_d = signed_i & a_i[WIDTH-1];
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + SHW'(1);
                if (is_div_q) begin
                    acc_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d  = mul_sum[WIDTH:1];
                    work_d = {mul_sum[0], work_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
                if (is_div_q) begin
                    // Divide by zero: every trial subtract succeeds, so the
                    // quotient is all ones and acc ends up holding |a|; with
                    // the sign of a restored that is a itself.
                    if (opnd_q == '0) begin
                        lo_fix_o = '1;
                    end else begin
                        lo_fix_o = neg_res_q ? -work_q : work_q;
                    end
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end else begin
                    lo_fix_o = prod_fix[WIDTH-1:0];
                    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hi_o    = hi_q;
    assign state_o = state_q;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered WIDTH-bit execute-stage ALU with iterative MUL/DIV.
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready.
// in_ready is low only while a MUL/DIV is in progress; in_valid during that
// time is ignored. out_valid is a one-cycle pulse with no backpressure, and
// result/zero/ovf hold their values between pulses.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_valid       op/a/b/md_signed valid this cycle
//   in_ready       unit can accept an op
//   op             operation code (alu_pkg::OP_*)
//   md_signed      MUL/DIV operands are two's complement
//   a, b           operands
//   out_valid      result/zero/ovf valid (one-cycle pulse)
//   result         registered result
//   zero           result == 0
//   ovf            signed overflow, ADD/SUB only
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             md_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    md_state_e        md_state;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic             accept;
    logic             is_md;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    assign in_ready = (md_state == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_md    = (op == OP_MUL) || (op == OP_DIV);
    assign shamt    = b[SHW-1:0];

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept & is_md),
        .is_div_i (op == OP_DIV),
        .signed_i (md_signed),
        .a_i      (a),
        .b_i      (b),
        .done_o   (md_done),
        .lo_fix_o (md_lo),
        .hi_o     (md_hi),
        .state_o  (md_state)
    );

    // ADD/SUB share one adder; op[2] selects a - b (a + ~b + 1).
    assign b_eff = op[2] ? ~b : b;
    assign sum   = op[2] ? (a - b) : (a + b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_ANDN: alu_res = a & ~b;
            OP_OR:   alu_res = a | b;
            OP_ORN:  alu_res = a | ~b;
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                // Overflow: effective operands agree in sign, sum does not.
                alu_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_MFHI: alu_res = md_hi;
            default: alu_res = '0;
        endcase
    end

    // FIX never overlaps an accept: in_ready is low throughout FIX.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        if (md_done) begin
            out_valid_d = 1'b1;
            result_d    = md_lo;
            zero_d      = (md_lo == '0);
            ovf_d       = 1'b0;
        end else if (accept && !is_md) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv (WIDTH=32): directed vectors, a behavioural model
// computed with plain integer arithmetic, an expected queue checked on every
// out_valid, and literal expectations for hand-computed vectors.
module tb_alu_muldiv;

    localparam int W = 32;

    localparam logic [3:0] C_AND  = 4'b0000, C_OR   = 4'b0001, C_ADD  = 4'b0010;
    localparam logic [3:0] C_SLTU = 4'b0011, C_ANDN = 4'b0100, C_ORN  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110, C_SLT  = 4'b0111, C_XOR  = 4'b1000;
    localparam logic [3:0] C_NOR  = 4'b1001, C_SLL  = 4'b1010, C_SRL  = 4'b1011;
    localparam logic [3:0] C_SRA  = 4'b1100, C_MUL  = 4'b1101, C_DIV  = 4'b1110;
    localparam logic [3:0] C_MFHI = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'b0;
    logic         md_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .md_signed (md_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         ov;
        int           cyc;
        logic [3:0]   op;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] last_res = '0;
    logic         last_z = 1'b0;
    logic         last_ov = 1'b0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the op definitions.
    function automatic void model(input logic [3:0] o, input logic s,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic v);
        longint sx, sy, tsum, q, rm;
        logic [2*W-1:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0;
        v = 1'b0;
        case (o)
            C_AND:  r = x & y;
            C_ANDN: r = x & ~y;
            C_OR:   r = x | y;
            C_ORN:  r = x | ~y;
            C_ADD: begin
                tsum = sx + sy;
                r = x + y;
                v = (tsum != longint'($signed(r)));
            end
            C_SUB: begin
                tsum = sx - sy;
                r = x - y;
                v = (tsum != longint'($signed(r)));
            end
            C_SLTU: r = (x < y) ? 32'd1 : 32'd0;
            C_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
            C_XOR:  r = x ^ y;
            C_NOR:  r = ~(x | y);
            C_SLL:  r = x << y[4:0];
            C_SRL:  r = x >> y[4:0];
            C_SRA:  r = $signed(x) >>> y[4:0];
            C_MUL: begin
                if (s) begin
                    q = sx * sy;
                    p = q;
                end else begin
                    p = {32'b0, x} * {32'b0, y};
                end
                model_hi = p[2*W-1:W];
                r = p[W-1:0];
            end
            C_DIV: begin
                if (y == '0) begin
                    r = '1;
                    model_hi = x;
                end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    r = x;
                    model_hi = '0;
                end else if (s) begin
                    q = sx / sy;
                    rm = sx % sy;
                    r = q[W-1:0];
                    model_hi = rm[W-1:0];
                end else begin
                    r = x / y;
                    model_hi = x % y;
                end
            end
            C_MFHI: r = model_hi;
            default: r = '0;
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("latency op=%h", e.op), cyc, e.cyc);
                    check($sformatf("result op=%h", e.op), result, e.res);
                    check($sformatf("zero op=%h", e.op), {31'b0, zero}, {31'b0, e.z});
                    check($sformatf("ovf op=%h", e.op), {31'b0, ovf}, {31'b0, e.ov});
                end
                last_res = result;
                last_z   = zero;
                last_ov  = ovf;
            end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                check($sformatf("missing out_valid op=%h", exp_q[0].op), cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Waits for in_ready at a falling edge, drives the op, records the
    // expected outcome and returns just after the accepting rising edge.
    task automatic issue(input logic [3:0] o, input logic s,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready wait timeout", 32'd0, 32'd1);
        end else begin
            op = o;
            md_signed = s;
            a = x;
            b = y;
            in_valid = 1'b1;
            model(o, s, x, y, e.res, e.ov);
            e.z = (e.res == '0);
            e.op = o;
            // accept edge is cyc+1; single-cycle ops report after that edge,
            // MUL/DIV after edge accept+W+1
            e.cyc = cyc + 1 + ((o == C_MUL || o == C_DIV) ? (W + 1) : 0);
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]   o;
        logic         s;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] lit;
        logic [W-1:0] hi_lit;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int cnt;

        vecs[0]  = '{C_SRA,  1'b0, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{C_SRL,  1'b0, 32'h8000_0000, 32'd31,        32'h0000_0001, 32'h0};
        vecs[2]  = '{C_SLL,  1'b0, 32'h0000_0001, 32'h20,        32'h0000_0001, 32'h0};
        vecs[3]  = '{C_XOR,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0};
        vecs[4]  = '{C_NOR,  1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'h0000_000F, 32'h0};
        vecs[5]  = '{C_ANDN, 1'b0, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0};
        vecs[6]  = '{C_ORN,  1'b0, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0};
        vecs[7]  = '{C_SUB,  1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0};
        vecs[8]  = '{C_AND,  1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 32'h0};
        vecs[9]  = '{C_OR,   1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 32'h0};
        vecs[10] = '{C_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[11] = '{C_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[12] = '{C_DIV,  1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
        vecs[13] = '{C_DIV,  1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[14] = '{C_DIV,  1'b1, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF8};
        vecs[15] = '{C_MUL,  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000};
        vecs[16] = '{C_SLT,  1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0};
        vecs[17] = '{C_ADD,  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0};
        vecs[18] = '{C_DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

        // reset state
        repeat (3) @(negedge clk);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset zero", {31'b0, zero}, 32'd0);
        check("reset ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;

        // ADD overflow
        issue(C_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1);
        drain();
        check("lit ADD result", last_res, 32'h8000_0000);
        check("lit ADD ovf", {31'b0, last_ov}, 32'd1);
        check("lit ADD zero", {31'b0, last_z}, 32'd0);

        // back-to-back single-cycle ops
        issue(C_SUB, 1'b0, 32'd5, 32'd5);
        issue(C_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1);
        issue(C_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1);
        drain();
        check("lit SLTU result", last_res, 32'd0);

        // signed MUL: count in_ready-low cycles, poke in_valid while busy
        issue(C_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
            in_valid = (cnt >= 5 && cnt < 8);
            if (in_valid) begin
                op = C_ADD;
                a = 32'd1;
                b = 32'd1;
            end
        end
        check("MUL in_ready low cycles", cnt, 32'd33);
        drain();
        check("lit MUL LO", last_res, 32'hFFFF_FFEB);
        issue(C_MFHI, 1'b0, 32'd0, 32'd0);
        drain();
        check("lit MUL HI", last_res, 32'hFFFF_FFFF);

        // signed DIV and divide by zero
        issue(C_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        drain();
        check("lit DIV LO", last_res, 32'hFFFF_FFFD);
        issue(C_MFHI, 1'b0, 32'd0, 32'd0);
        drain();
        check("lit DIV HI", last_res, 32'hFFFF_FFFF);
        issue(C_DIV, 1'b0, 32'd7, 32'd0);
        drain();
        check("lit DIV0 LO", last_res, 32'hFFFF_FFFF);
        issue(C_MFHI, 1'b0, 32'd0, 32'd0);
        drain();
        check("lit DIV0 HI", last_res, 32'd7);

        // directed table
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].s, vecs[i].x, vecs[i].y);
            drain();
            check($sformatf("lit vec%0d", i), last_res, vecs[i].lit);
            if (vecs[i].o == C_MUL || vecs[i].o == C_DIV) begin
                issue(C_MFHI, 1'b0, 32'd0, 32'd0);
                drain();
                check($sformatf("lit vec%0d HI", i), last_res, vecs[i].hi_lit);
            end
        end

        // reset in the middle of a MUL
        issue(C_MUL, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_hi = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort result", result, 32'd0);
        repeat (40) @(negedge clk);
        issue(C_MFHI, 1'b0, 32'd0, 32'd0);
        drain();
        check("lit HI after abort", last_res, 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
